// File: rtl/wash_ctrl_pkg.sv
// Shared wash-controller constants: state codes, stage times, mode table, water range.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package wash_ctrl_pkg;

  // System clock rate; one-second tick period by default.
  localparam int CLK_HZ = 50_000_000;

  // Stage durations in seconds, consumed by the run-mode datapath.
  localparam int WASH_S  = 300;
  localparam int RINSE_S = 180;
  localparam int DRY_S   = 240;

  // Controller state codes as shown on the display.
  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_SEL   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  // Stage mask: bit0 wash, bit1 rinse, bit2 dry. Power-up program is all stages.
  localparam logic [2:0] MODE_RST = 3'b111;

  // Water-level range in datapath units.
  localparam logic [5:0] WAT_MIN = 6'd2;
  localparam logic [5:0] WAT_MAX = 6'd6;
  localparam logic [5:0] WAT_RST = 6'd3;

  // Mode sequence: 111 -> 001 -> 011 -> 010 -> 110 -> 100 -> 111.
  function automatic logic [2:0] mode_next(input logic [2:0] cur);
    case (cur)
      3'b111:  mode_next = 3'b001;
      3'b001:  mode_next = 3'b011;
      3'b011:  mode_next = 3'b010;
      3'b010:  mode_next = 3'b110;
      3'b110:  mode_next = 3'b100;
      3'b100:  mode_next = 3'b111;
      default: mode_next = MODE_RST;
    endcase
  endfunction

  // Water level steps up by one and wraps from the top of the range to the bottom.
  function automatic logic [5:0] wat_next(input logic [5:0] cur);
    if (cur >= WAT_MAX || cur < WAT_MIN) wat_next = WAT_MIN;
    else                                 wat_next = cur + 6'd1;
  endfunction

endpackage

// File: rtl/wash_tick.sv
// One-second strobe generator: tick is high for one cycle every TIM_CMAX cycles.
// Latency: first tick TIM_CMAX cycles after reset or clr; tick decodes the counter register.
// Backpressure: none; clr restarts the period so timing is measured from a state change.
module wash_tick #(
  parameter int TIM_CMAX = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TIM_CMAX > 1) ? $clog2(TIM_CMAX) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(TIM_CMAX - 1);

  logic [CW-1:0] cnt;

  // Free-running period counter, restarted on clr and on reaching the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt <= '0;
    else if (clr || cnt == CNT_TOP) cnt <= '0;
    else                            cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == CNT_TOP);

endmodule

// File: rtl/wash_ctrl.sv
// Washing-machine front-panel controller: power, program select, run/pause, finish beep.
// Latency: every output changes on the clock edge after the causing input pulse.
// Backpressure: none; every button and run_done pulse is acted on or dropped in its cycle.
module wash_ctrl
  import wash_ctrl_pkg::*;
#(
  parameter int TIM_CMAX = CLK_HZ,
  parameter int IDLE_S   = 10,
  parameter int BEEP_S   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_pwr,
  input  logic       btn_start,
  input  logic       btn_mode,
  input  logic       btn_wat,
  input  logic       run_done,
  output logic [2:0] init,
  output logic [5:0] u_wat,
  output logic       pau,
  output logic       clr,
  output logic       pwr_on,
  output logic       lock,
  output logic       beep,
  output logic [2:0] st_out
);

  localparam int IW = (IDLE_S > 1) ? $clog2(IDLE_S + 1) : 1;
  localparam int BW = (BEEP_S > 1) ? $clog2(BEEP_S + 1) : 1;

  state_t        state, state_nxt;
  logic [IW-1:0] idle_cnt, idle_nxt;
  logic [BW-1:0] beep_cnt, beep_nxt;
  logic [2:0]    init_nxt;
  logic [5:0]    wat_nxt;
  logic          st_chg;
  logic          tick;

  assign st_chg = (state_nxt != state);
  assign st_out = state;

  wash_tick #(.TIM_CMAX(TIM_CMAX)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (st_chg),
    .tick  (tick)
  );

  // Next state, program registers and timeout counters; btn_pwr outranks everything.
  // In RUN, run_done outranks btn_start so a completed program is never lost to a pause.
  always_comb begin
    state_nxt = state;
    init_nxt  = init;
    wat_nxt   = u_wat;
    idle_nxt  = idle_cnt;
    beep_nxt  = beep_cnt;
    case (state)
      ST_OFF: begin
        if (btn_pwr) state_nxt = ST_SEL;
      end
      ST_SEL: begin
        if (btn_pwr)        state_nxt = ST_OFF;
        else if (btn_start) state_nxt = ST_RUN;
        else if (btn_mode || btn_wat) begin
          if (btn_mode) init_nxt = mode_next(init);
          if (btn_wat)  wat_nxt  = wat_next(u_wat);
          idle_nxt = '0;
        end else if (tick) begin
          if (idle_cnt == IW'(IDLE_S - 1)) state_nxt = ST_OFF;
          else                             idle_nxt  = idle_cnt + IW'(1);
        end
      end
      ST_RUN: begin
        if (btn_pwr)        state_nxt = ST_OFF;
        else if (run_done)  state_nxt = ST_FIN;
        else if (btn_start) state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (btn_pwr)        state_nxt = ST_OFF;
        else if (btn_start) state_nxt = ST_RUN;
      end
      ST_FIN: begin
        if (btn_pwr)        state_nxt = ST_OFF;
        else if (btn_start) state_nxt = ST_SEL;
        else if (tick) begin
          if (beep_cnt == BW'(BEEP_S - 1)) state_nxt = ST_SEL;
          else                             beep_nxt  = beep_cnt + BW'(1);
        end
      end
      default: state_nxt = ST_OFF;
    endcase
    if (state_nxt != state) begin
      idle_nxt = '0;
      beep_nxt = '0;
    end
  end

  // State register and registered panel/datapath outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_OFF;
      pau    <= 1'b1;
      clr    <= 1'b0;
      lock   <= 1'b0;
      beep   <= 1'b0;
      pwr_on <= 1'b0;
    end else begin
      state  <= state_nxt;
      pau    <= (state_nxt != ST_RUN);
      clr    <= (state == ST_SEL) && (state_nxt == ST_RUN);
      lock   <= (state_nxt == ST_RUN) || (state_nxt == ST_PAUSE);
      beep   <= (state_nxt == ST_FIN);
      pwr_on <= (state_nxt != ST_OFF);
    end
  end

  // Program selection (kept through power-off) and the idle/beep tick counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init     <= MODE_RST;
      u_wat    <= WAT_RST;
      idle_cnt <= '0;
      beep_cnt <= '0;
    end else begin
      init     <= init_nxt;
      u_wat    <= wat_nxt;
      idle_cnt <= idle_nxt;
      beep_cnt <= beep_nxt;
    end
  end

endmodule
